// File: rtl/gdi_serial_logic_ctrl.sv
// gdi_serial_logic_ctrl
// Bit-serial sequencer for an external 1-bit GDI gate slice. A request
// latches the operands, then one bit per cycle (LSB first) is driven to the
// slice and the slice output is captured into result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a, b     operation request, opcode and operands
//   abort               cancel an operation in progress
//   gate_sel/a/b/en     drive to the gate slice
//   gate_y              combinational gate slice output
//   ready, busy, done   handshake / status
//   err, result         error flag and WIDTH-bit result
module gdi_serial_logic_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic [2:0]       gate_sel,
  output logic             gate_a,
  output logic             gate_b,
  output logic             gate_en,
  input  logic             gate_y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_prev;

  // Index of the bit presented to the slice in the following RUN cycle
  always_comb begin
    idx_nxt = idx + IW'(1);
  end

  assign gate_sel = op_q;

  // Sequencer: state, operand latches, gate drive and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      op_q        <= 3'b000;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      result_prev <= '0;
      gate_a      <= 1'b0;
      gate_b      <= 1'b0;
      gate_en     <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Snapshot lets an abort put back the last completed result
            result_prev <= result;
            if (op == OP_RSV) begin
              state  <= DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
              ready  <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state   <= RUN;
              a_q     <= a;
              b_q     <= b;
              op_q    <= op;
              idx     <= '0;
              err     <= 1'b0;
              ready   <= 1'b0;
              busy    <= 1'b1;
              gate_en <= 1'b1;
              gate_a  <= a[0];
              gate_b  <= (op == OP_NOT) ? 1'b0 : b[0];
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            err     <= 1'b1;
            result  <= result_prev;
            ready   <= 1'b1;
            busy    <= 1'b0;
            gate_en <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
          end else begin
            result[idx] <= gate_y;
            if (idx == LAST_IDX) begin
              // idx holds at the last bit rather than wrapping
              state   <= DONE;
              done    <= 1'b1;
              ready   <= 1'b1;
              busy    <= 1'b0;
              gate_en <= 1'b0;
              gate_a  <= 1'b0;
              gate_b  <= 1'b0;
            end else begin
              idx    <= idx_nxt;
              gate_a <= a_q[idx_nxt];
              gate_b <= (op_q == OP_NOT) ? 1'b0 : b_q[idx_nxt];
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
